sys_arr_feeder: RTL and testbench

Transmit-side driver for one `sysArrRow` systolic row. It accepts one weight/bias beat and an activation stream over valid/ready handshakes. It buffers activations in a small FIFO, loads the row's weights with a single `wwrite` strobe, then streams activations into `datain` with `active` held high. After the tagged last activation it flushes the row pipeline with zero data and pulses `done`.

---
 rtl/sys_arr_feeder.sv | 203 ++++++++++++++++++++
 tb/tb_sys_arr_feeder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_arr_feeder.sv
// sys_arr_feeder: loads one sysArrRow's weights/bias, then streams buffered activations and flushes the row.
// Optional feature macro SYS_ARR_FEEDER_BUBBLE_CNT_EN adds a saturating count of empty-FIFO stream cycles.
module sys_arr_feeder #(
  parameter int row_width    = 4,
  parameter int fifo_depth   = 8,
  parameter int drain_cycles = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    w_valid,
  output logic                    w_ready,
  input  logic [8*row_width-1:0]  w_data,
  input  logic [16*row_width-1:0] b_data,
  input  logic                    a_valid,
  output logic                    a_ready,
  input  logic [7:0]              a_data,
  input  logic                    a_last,
  output logic [8*row_width-1:0]  win,
  output logic [row_width-1:0]    wwrite,
  output logic [16*row_width-1:0] sumin,
  output logic [7:0]              datain,
  output logic                    active,
  output logic                    busy,
  output logic                    done
`ifdef SYS_ARR_FEEDER_BUBBLE_CNT_EN
  ,
  output logic [15:0]             bubble_cnt
`endif
);

  localparam int ptr_w  = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam int cnt_w  = ptr_w + 1;
  localparam int dcnt_w = (drain_cycles > 1) ? $clog2(drain_cycles) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t                  state_r, state_s;
  logic [8:0]              mem_r [fifo_depth];
  logic [ptr_w-1:0]        wr_ptr_r, rd_ptr_r;
  logic [cnt_w-1:0]        count_r;
  logic                    push_s, pop_s, full_s, empty_s;
  logic [8:0]              head_s;
  logic [8*row_width-1:0]  win_r, win_s;
  logic [16*row_width-1:0] sumin_r, sumin_s;
  logic [row_width-1:0]    wwrite_r, wwrite_s;
  logic [7:0]              datain_r, datain_s;
  logic                    active_r, active_s;
  logic                    done_r, done_s;
  logic [dcnt_w-1:0]       drain_cnt_r, drain_cnt_s;
  logic                    w_accept_s;

  assign full_s  = (count_r == cnt_w'(fifo_depth));
  assign empty_s = (count_r == cnt_w'(0));
  assign head_s  = mem_r[rd_ptr_r];
  // a_ready depends only on the registered count, never on a_valid
  assign push_s  = a_valid && !full_s;
  assign a_ready = !full_s;
  assign w_ready = (state_r == IDLE);
  assign busy    = (state_r != IDLE);

  assign win    = win_r;
  assign sumin  = sumin_r;
  assign wwrite = wwrite_r;
  assign datain = datain_r;
  assign active = active_r;
  assign done   = done_r;

  // Next-state and next-output decode for the pass sequencer
  always_comb begin
    state_s     = state_r;
    win_s       = win_r;
    sumin_s     = sumin_r;
    wwrite_s    = {row_width{1'b0}};
    datain_s    = 8'h00;
    active_s    = active_r;
    done_s      = 1'b0;
    drain_cnt_s = drain_cnt_r;
    pop_s       = 1'b0;
    w_accept_s  = 1'b0;
    case (state_r)
      IDLE: begin
        active_s = 1'b0;
        if (w_valid) begin
          w_accept_s = 1'b1;
          win_s      = w_data;
          sumin_s    = b_data;
          wwrite_s   = {row_width{1'b1}};
          state_s    = LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        active_s = 1'b1;
        state_s  = STREAM;
      end
      STREAM: begin
        active_s = 1'b1;
        if (!empty_s) begin
          pop_s    = 1'b1;
          datain_s = head_s[7:0];
          if (head_s[8]) begin
            state_s     = DRAIN;
            drain_cnt_s = dcnt_w'(drain_cycles - 1);
          end else begin
            state_s = STREAM;
          end
        end else begin
          datain_s = 8'h00;
        end
      end
      DRAIN: begin
        if (drain_cnt_r == dcnt_w'(0)) begin
          done_s   = 1'b1;
          active_s = 1'b0;
          state_s  = IDLE;
        end else begin
          drain_cnt_s = drain_cnt_r - dcnt_w'(1);
          active_s    = 1'b1;
        end
      end
      default: begin
        active_s = 1'b0;
        state_s  = IDLE;
      end
    endcase
  end

  // State and registered row-facing outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= IDLE;
      win_r       <= {(8*row_width){1'b0}};
      sumin_r     <= {(16*row_width){1'b0}};
      wwrite_r    <= {row_width{1'b0}};
      datain_r    <= 8'h00;
      active_r    <= 1'b0;
      done_r      <= 1'b0;
      drain_cnt_r <= dcnt_w'(0);
    end else begin
      state_r     <= state_s;
      win_r       <= win_s;
      sumin_r     <= sumin_s;
      wwrite_r    <= wwrite_s;
      datain_r    <= datain_s;
      active_r    <= active_s;
      done_r      <= done_s;
      drain_cnt_r <= drain_cnt_s;
    end
  end

  // FIFO storage; contents need no reset since the count gates every read
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {a_last, a_data};
    end
  end

  // FIFO pointers and occupancy; power-of-2 depth lets pointers wrap naturally
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_r <= ptr_w'(0);
      rd_ptr_r <= ptr_w'(0);
      count_r  <= cnt_w'(0);
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + ptr_w'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + ptr_w'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + cnt_w'(1);
        2'b01:   count_r <= count_r - cnt_w'(1);
        default: count_r <= count_r;
      endcase
    end
  end

`ifdef SYS_ARR_FEEDER_BUBBLE_CNT_EN
  logic [15:0] bubble_cnt_r;
  assign bubble_cnt = bubble_cnt_r;

  // Saturating count of STREAM cycles that found the FIFO empty
  always_ff @(posedge clock) begin
    if (reset) begin
      bubble_cnt_r <= 16'h0000;
    end else if (w_accept_s) begin
      bubble_cnt_r <= 16'h0000;
    end else if ((state_r == STREAM) && empty_s && (bubble_cnt_r != 16'hFFFF)) begin
      bubble_cnt_r <= bubble_cnt_r + 16'h0001;
    end else begin
      bubble_cnt_r <= bubble_cnt_r;
    end
  end
`endif

endmodule

// File: tb/tb_sys_arr_feeder.sv
// Scoreboard bench for sys_arr_feeder: stimulus queues expected datain/done beats, a monitor checks them.
module tb_sys_arr_feeder;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        w_valid = 1'b0;
  logic        w_ready;
  logic [31:0] w_data = 32'h0;
  logic [63:0] b_data = 64'h0;
  logic        a_valid = 1'b0;
  logic        a_ready;
  logic [7:0]  a_data = 8'h0;
  logic        a_last = 1'b0;
  logic [31:0] win;
  logic [3:0]  wwrite;
  logic [63:0] sumin;
  logic [7:0]  datain;
  logic        active;
  logic        busy;
  logic        done;
`ifdef SYS_ARR_FEEDER_BUBBLE_CNT_EN
  logic [15:0] bubble_cnt;
`endif

  always #5 clock = ~clock;

  sys_arr_feeder #(.row_width(4), .fifo_depth(8), .drain_cycles(4)) dut (
    .clock(clock), .reset(reset),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .b_data(b_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_last(a_last),
    .win(win), .wwrite(wwrite), .sumin(sumin), .datain(datain),
    .active(active), .busy(busy), .done(done)
`ifdef SYS_ARR_FEEDER_BUBBLE_CNT_EN
    , .bubble_cnt(bubble_cnt)
`endif
  );

  int checks = 0;
  int failures = 0;
  logic [7:0]  exp_data[$];
  logic [31:0] exp_done[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [7:0] d, input logic last);
    a_valid = 1'b1;
    a_data  = d;
    a_last  = last;
    tick();
    a_valid = 1'b0;
    a_last  = 1'b0;
  endtask

  task automatic load_w(input logic [31:0] wd, input logic [63:0] bd);
    w_valid = 1'b1;
    w_data  = wd;
    b_data  = bd;
    tick();
    w_valid = 1'b0;
  endtask

  task automatic expect_pass(input logic [7:0] bytes[$], input logic [31:0] wexp);
    exp_data.push_back(8'h00);
    foreach (bytes[i]) exp_data.push_back(bytes[i]);
    for (int i = 0; i < 3; i++) exp_data.push_back(8'h00);
    exp_done.push_back(wexp);
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (done === 1'b1) seen = 1'b1;
    end
    check(name, 64'(seen), 64'd1);
  endtask

  // Monitor: every active cycle consumes one expected datain beat; every done pulse one expected win
  always @(negedge clock) begin
    if (active === 1'b1) begin
      if (exp_data.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL datain_unexpected actual=%0h expected=none", datain);
      end else begin
        check("datain", 64'(datain), 64'(exp_data.pop_front()));
      end
    end
    if (done === 1'b1) begin
      if (exp_done.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL done_unexpected actual=1 expected=0");
      end else begin
        check("done_win", 64'(win), 64'(exp_done.pop_front()));
      end
      check("done_datain", 64'(datain), 64'd0);
      check("done_w_ready", 64'(w_ready), 64'd1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];

    // Reset values
    tick();
    tick();
    reset = 1'b0;
    check("rst_win", 64'(win), 64'd0);
    check("rst_sumin", sumin, 64'd0);
    check("rst_wwrite", 64'(wwrite), 64'd0);
    check("rst_datain", 64'(datain), 64'd0);
    check("rst_active", 64'(active), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_w_ready", 64'(w_ready), 64'd1);
    check("rst_a_ready", 64'(a_ready), 64'd1);

    // Prefetch in IDLE, then weight load and full pass
    push(8'h01, 1'b0);
    push(8'h02, 1'b0);
    push(8'h03, 1'b0);
    push(8'h04, 1'b1);
    q = '{8'h01, 8'h02, 8'h03, 8'h04};
    expect_pass(q, 32'h9999_9999);
    load_w(32'h9999_9999, 64'h1);
    check("ld_wwrite", 64'(wwrite), 64'hF);
    check("ld_win", 64'(win), 64'h9999_9999);
    check("ld_sumin", sumin, 64'h1);
    check("ld_active", 64'(active), 64'd0);
    check("ld_busy", 64'(busy), 64'd1);
    check("ld_w_ready", 64'(w_ready), 64'd0);
    tick();
    check("ld1_wwrite", 64'(wwrite), 64'd0);
    check("ld1_active", 64'(active), 64'd1);
    check("ld1_sumin", sumin, 64'h1);
    wait_done("pass1_done");
    check("pass1_active", 64'(active), 64'd0);
    check("pass1_busy", 64'(busy), 64'd0);
`ifdef SYS_ARR_FEEDER_BUBBLE_CNT_EN
    check("pass1_bubbles", 64'(bubble_cnt), 64'd0);
`endif

    // Fill FIFO to 8, 9th byte held off until the first pop
    for (int i = 0; i < 8; i++) begin
      check("fill_a_ready", 64'(a_ready), 64'd1);
      push(8'(8'h10 + i), 1'b0);
    end
    a_valid = 1'b1;
    a_data  = 8'h18;
    a_last  = 1'b1;
    check("full_a_ready", 64'(a_ready), 64'd0);
    tick();
    check("full_hold_a_ready", 64'(a_ready), 64'd0);
    q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
    expect_pass(q, 32'hC3C3_3C3C);
    load_w(32'hC3C3_3C3C, 64'h5);
    check("full_e0_a_ready", 64'(a_ready), 64'd0);
    tick();
    check("full_e1_a_ready", 64'(a_ready), 64'd0);
    tick();
    check("full_pop_a_ready", 64'(a_ready), 64'd1);
    tick();
    a_valid = 1'b0;
    a_last  = 1'b0;
    check("full_pushpop_a_ready", 64'(a_ready), 64'd1);
    wait_done("pass2_done");

    // Starved stream: three bubbles
    q = '{8'h00, 8'h00, 8'h00, 8'h21, 8'h22};
    expect_pass(q, 32'h0F0F_F0F0);
    load_w(32'h0F0F_F0F0, 64'h7);
    tick();
    tick();
    check("bub_datain", 64'(datain), 64'd0);
    check("bub_active", 64'(active), 64'd1);
    tick();
    a_valid = 1'b1;
    a_data  = 8'h21;
    tick();
    check("bub3_datain", 64'(datain), 64'd0);
    a_data = 8'h22;
    a_last = 1'b1;
    tick();
    a_valid = 1'b0;
    a_last  = 1'b0;
    check("bub_first_data", 64'(datain), 64'h21);
    wait_done("pass3_done");
`ifdef SYS_ARR_FEEDER_BUBBLE_CNT_EN
    check("pass3_bubbles", 64'(bubble_cnt), 64'd3);
`endif

    // Reset mid-STREAM with 5 entries queued; w_valid during the pass is ignored
    for (int i = 0; i < 8; i++) push(8'(8'h30 + i), 1'b0);
    exp_data.push_back(8'h00);
    exp_data.push_back(8'h30);
    exp_data.push_back(8'h31);
    exp_data.push_back(8'h32);
    load_w(32'hA5A5_5A5A, 64'h2222);
    tick();
    tick();
    tick();
    w_valid = 1'b1;
    w_data  = 32'h1234_5678;
    tick();
    w_valid = 1'b0;
    check("ign_win", 64'(win), 64'hA5A5_5A5A);
    check("ign_w_ready", 64'(w_ready), 64'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst_win", 64'(win), 64'd0);
    check("mrst_sumin", sumin, 64'd0);
    check("mrst_wwrite", 64'(wwrite), 64'd0);
    check("mrst_datain", 64'(datain), 64'd0);
    check("mrst_active", 64'(active), 64'd0);
    check("mrst_busy", 64'(busy), 64'd0);
    check("mrst_done", 64'(done), 64'd0);
    check("mrst_w_ready", 64'(w_ready), 64'd1);
    check("mrst_a_ready", 64'(a_ready), 64'd1);

    // Back-to-back passes; next pass's bytes pushed during DRAIN
    push(8'h51, 1'b0);
    push(8'h52, 1'b1);
    q = '{8'h51, 8'h52};
    expect_pass(q, 32'h1111_1111);
    load_w(32'h1111_1111, 64'h3);
    tick();
    tick();
    tick();
    check("b2b_in_drain", 64'(busy), 64'd1);
    push(8'h61, 1'b0);
    push(8'h62, 1'b0);
    push(8'h63, 1'b1);
    wait_done("pass5_done");
    q = '{8'h61, 8'h62, 8'h63};
    expect_pass(q, 32'h2222_2222);
    load_w(32'h2222_2222, 64'h4);
    wait_done("pass6_done");

    tick();
    tick();
    check("exp_data_left", 64'(exp_data.size()), 64'd0);
    check("exp_done_left", 64'(exp_done.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
